mux16_rr_scheduler: RTL and testbench
=====================================

// Module: mux16_rr_scheduler
// PURPOSE
//  Round-robin scheduler that shares the 16:1 mux (mux_16to1) among 16 requesters.
//  Drives the mux Sel from a registered grant and holds Sel stable for the whole grant.
//  Forces one dead cycle between grants (break-before-make) so the mux output never
//  glitches between owners. A grant ends on release, on request drop, or on hold timeout.
// PARAMETERS
//  N         16  number of requesters (mux inputs); fixed to 16 in this revision
//  SEL_W     4   select width, clog2(N)
//  MAX_HOLD  8   max cycles a grant may last; 0 disables the timeout
// PORTS
//  clk          in   1      rising-edge clock (single clock domain)
//  reset        in   1      synchronous, active-high reset
//  req          in   N      per-requester request, level-sensitive
//  done         in   1      current owner releases the mux (sampled only in GRANT)
//  sel          out  SEL_W  mux select, registered; connects to mux_16to1 Sel
//  grant        out  N      one-hot grant, registered; all-zero when no grant
//  grant_valid  out  1      high while a grant is active
//  timeout      out  1      1-cycle pulse when a grant is revoked by MAX_HOLD
// BEHAVIOUR
//  Reset
//   - When reset=1 at a clk edge: state=IDLE, sel=0, grant=0, grant_valid=0,
//     timeout=0, ptr=0, hold_cnt=0.
//   - Reset wins over every other input, including mid-grant.
//  FSM with two states, IDLE and GRANT
//   - IDLE, |req==1:
//     - Choose the first i with req[i]=1, searching circularly from ptr (ptr, ptr+1, ..., 15, 0, ...).
//     - Next edge: sel=i, grant=1<<i, grant_valid=1, hold_cnt=0, state=GRANT.
//     - Latency is 1 cycle from req sampled high to grant_valid high.
//   - IDLE, req==0: outputs unchanged; sel keeps the last granted value, grant=0.
//   - GRANT: sel and grant are frozen. Other req bits are ignored. hold_cnt increments each cycle.
//   - GRANT release conditions, priority high to low:
//     - done=1
//     - req[sel]=0
//     - MAX_HOLD!=0 and hold_cnt==MAX_HOLD-1
//   - On release, next edge: grant=0, grant_valid=0, ptr=(sel+1) mod 16, state=IDLE.
//     - ptr wraps 15 -> 0.
//     - sel is NOT cleared.
//   - timeout=1 for exactly the release edge, and only if the release was caused
//     solely by MAX_HOLD.
//     - done=1 or req[sel]=0 in the same cycle suppresses the timeout pulse.
//   - Back-to-back grants: grant_valid is low for exactly 1 cycle (the IDLE cycle) between grants.
//  Arithmetic
//   - hold_cnt width = clog2(MAX_HOLD+1); it never wraps, because release happens first.
//   - ptr is SEL_W bits; the increment is modulo 2^SEL_W.
//  Boundary conditions
//   - Single requester, continuous req: it is re-granted every other cycle pair (grant, gap).
//   - All 16 requesting: grants rotate in order 0,1,...,15,0 (fairness bound: 16 grants).
//   - MAX_HOLD=1: each grant lasts exactly 1 cycle; timeout pulses unless done or a req drop occurs.
//   - done asserted in IDLE: ignored.
// STRUCTURE
//  - Package mux16_pkg holds:
//    - localparams N=16, SEL_W=4
//    - state encoding ST_IDLE=1'b0, ST_GRANT=1'b1
//  - Sub-module rr_pick16 (combinational):
//    - Inputs: req[15:0], ptr[3:0].
//    - Outputs: idx[3:0], any.
//    - Function: circular find-first via a doubled-vector priority search.
//  - Top level: FSM, hold counter, ptr register, output registers.
// TESTING
//  - Reset mid-grant:
//    - Stimulus: req=16'h0010, then reset=1 for 1 cycle while grant_valid=1.
//    - Response: next edge sel=0, grant=0, grant_valid=0; after reset, req[4] is re-granted 1 cycle later.
//  - Full rotation:
//    - Stimulus: req=16'hFFFF, done pulsed 1 cycle after each grant.
//    - Response: sel sequence 0,1,2,...,15,0; grant_valid low 1 cycle between each grant.
//  - Skip idle requesters:
//    - Stimulus: req=16'hAAAA (odd bits) with ptr=0.
//    - Response: sel=1,3,5,...,15,1; each grant is one-hot and matches sel.
//  - Timeout:
//    - Stimulus: MAX_HOLD=8, req=16'h0100 held, done=0.
//    - Response: grant_valid high 8 cycles, timeout pulses once at release, next grant after 1 gap cycle.
//  - Simultaneous events:
//    - Stimulus: done=1 on the same cycle hold_cnt==MAX_HOLD-1.
//    - Response: release occurs, timeout stays 0, ptr=sel+1.
//  - Request drop:
//    - Stimulus: req[15] granted, then req[15] deasserted, with req[0] high.
//    - Response: release next edge, ptr wraps to 0, sel=0 granted after the gap cycle.

Source files
------------

// File: rtl/mux16_pkg.sv
// Shared constants and types for the 16-way round-robin mux scheduler.
package mux16_pkg;

    localparam int unsigned N     = 16;
    localparam int unsigned SEL_W = 4;

    // Scheduler FSM: waiting for a request, or holding the mux for one owner.
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_e;

    // One-hot decode of a mux select value.
    function automatic logic [N-1:0] sel_to_onehot(input logic [SEL_W-1:0] sel);
        logic [N-1:0] v;
        v      = '0;
        v[sel] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/rr_pick16.sv
// Circular find-first: returns the first set request at or after ptr, wrapping 15 -> 0.
module rr_pick16
    import mux16_pkg::*;
(
    input  logic [N-1:0]     req,
    input  logic [SEL_W-1:0] ptr,
    output logic [SEL_W-1:0] idx,
    output logic             any
);

    logic [2*N-1:0]   w_dbl;
    logic [N-1:0]     w_rot;
    logic [SEL_W-1:0] w_off;

    // Doubling the vector turns the circular search into a plain shift plus a linear one.
    assign w_dbl = {req, req};
    assign w_rot = w_dbl[ptr +: N];

    // Lowest set bit of the rotated vector is the offset from ptr of the winner.
    always_comb begin
        w_off = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_off = SEL_W'(i);
            end
        end
    end

    // Offset back to an absolute index; the 4-bit add wraps naturally.
    assign idx = w_off + ptr;
    assign any = |req;

endmodule

// File: rtl/mux16_rr_scheduler.sv
// Round-robin owner scheduler for a shared 16:1 mux. Grants are registered, sel is held
// for the whole grant, and one dead cycle separates consecutive grants so the mux never
// switches directly from one owner to another.
module mux16_rr_scheduler
    import mux16_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N-1:0]     req,
    input  logic             done,
    output logic [SEL_W-1:0] sel,
    output logic [N-1:0]     grant,
    output logic             grant_valid,
    output logic             timeout
);

    // A timeout-disabled build still needs a 1-bit counter to keep the logic legal.
    localparam int unsigned HOLD_W        = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
    localparam int unsigned HOLD_LAST_INT = (MAX_HOLD == 0) ? 0 : MAX_HOLD - 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_LAST_INT);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = '1;
    localparam bit               TO_EN      = (MAX_HOLD != 0);

    state_e            r_state;
    state_e            w_state_d;
    logic [SEL_W-1:0]  r_sel;
    logic [SEL_W-1:0]  w_sel_d;
    logic [N-1:0]      r_grant;
    logic [N-1:0]      w_grant_d;
    logic              r_grant_valid;
    logic              w_grant_valid_d;
    logic              r_timeout;
    logic              w_timeout_d;
    logic [SEL_W-1:0]  r_ptr;
    logic [SEL_W-1:0]  w_ptr_d;
    logic [HOLD_W-1:0] r_hold_cnt;
    logic [HOLD_W-1:0] w_hold_cnt_d;

    logic [SEL_W-1:0]  w_pick_idx;
    logic              w_pick_any;
    logic              w_rel_done;
    logic              w_rel_drop;
    logic              w_rel_to;
    logic              w_release;

    rr_pick16 u_pick (
        .req (req),
        .ptr (r_ptr),
        .idx (w_pick_idx),
        .any (w_pick_any)
    );

    // Release causes while owning the mux; done and a request drop outrank the timeout.
    assign w_rel_done = done;
    assign w_rel_drop = ~req[r_sel];
    assign w_rel_to   = TO_EN && (r_hold_cnt == HOLD_LAST);
    assign w_release  = w_rel_done | w_rel_drop | w_rel_to;

    // Next-state and next-output logic for the two-state scheduler.
    always_comb begin
        w_state_d       = r_state;
        w_sel_d         = r_sel;
        w_grant_d       = r_grant;
        w_grant_valid_d = r_grant_valid;
        w_timeout_d     = 1'b0;
        w_ptr_d         = r_ptr;
        w_hold_cnt_d    = r_hold_cnt;

        unique case (r_state)
            ST_IDLE: begin
                // done is meaningless without an owner and is ignored here.
                if (w_pick_any) begin
                    w_state_d       = ST_GRANT;
                    w_sel_d         = w_pick_idx;
                    w_grant_d       = sel_to_onehot(w_pick_idx);
                    w_grant_valid_d = 1'b1;
                    w_hold_cnt_d    = '0;
                end
            end
            ST_GRANT: begin
                if (w_release) begin
                    // sel stays put so the mux keeps a stable input during the dead cycle.
                    w_state_d       = ST_IDLE;
                    w_grant_d       = '0;
                    w_grant_valid_d = 1'b0;
                    w_ptr_d         = r_sel + SEL_W'(1);
                    w_timeout_d     = w_rel_to & ~w_rel_done & ~w_rel_drop;
                end else if (r_hold_cnt != HOLD_MAX) begin
                    // Saturation only matters when the timeout is disabled.
                    w_hold_cnt_d = r_hold_cnt + HOLD_W'(1);
                end
            end
            default: begin
                w_state_d = ST_IDLE;
            end
        endcase
    end

    // State, pointer, counter and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_sel         <= '0;
            r_grant       <= '0;
            r_grant_valid <= 1'b0;
            r_timeout     <= 1'b0;
            r_ptr         <= '0;
            r_hold_cnt    <= '0;
        end else begin
            r_state       <= w_state_d;
            r_sel         <= w_sel_d;
            r_grant       <= w_grant_d;
            r_grant_valid <= w_grant_valid_d;
            r_timeout     <= w_timeout_d;
            r_ptr         <= w_ptr_d;
            r_hold_cnt    <= w_hold_cnt_d;
        end
    end

    assign sel         = r_sel;
    assign grant       = r_grant;
    assign grant_valid = r_grant_valid;
    assign timeout     = r_timeout;

endmodule

// File: tb/tb_mux16_rr_scheduler.sv
// Directed bench for mux16_rr_scheduler: a MAX_HOLD=8 instance for the main scenarios and a
// MAX_HOLD=1 instance for the single-cycle-grant boundary.
module tb_mux16_rr_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] req;
    logic        done;
    logic [3:0]  sel;
    logic [15:0] grant;
    logic        grant_valid;
    logic        timeout;

    logic [15:0] req1;
    logic        done1;
    logic [3:0]  sel1;
    logic [15:0] grant1;
    logic        grant_valid1;
    logic        timeout1;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mux16_rr_scheduler #(.MAX_HOLD(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .done        (done),
        .sel         (sel),
        .grant       (grant),
        .grant_valid (grant_valid),
        .timeout     (timeout)
    );

    mux16_rr_scheduler #(.MAX_HOLD(1)) dut1 (
        .clk         (clk),
        .reset       (reset),
        .req         (req1),
        .done        (done1),
        .sel         (sel1),
        .grant       (grant1),
        .grant_valid (grant_valid1),
        .timeout     (timeout1)
    );

    // One clock edge, then settle so outputs are sampled away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req   = '0;
        done  = 1'b0;
        req1  = '0;
        done1 = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        logic [21:0] exp;
        reset = 1'b1;
        req   = 16'hFFFF;
        done  = 1'b0;
        tick();
        exp = '0;
        n_tests++;
        if ({sel, grant, grant_valid, timeout} !== exp) begin
            n_fail++;
            $display("FAIL reset_state: got sel=%h grant=%h gv=%b to=%b, expected all zero",
                     sel, grant, grant_valid, timeout);
        end
        reset = 1'b0;
        req   = '0;
    endtask

    task automatic test_reset_mid_grant();
        do_reset();
        req = 16'h0010;
        tick();
        n_tests++;
        if ({grant_valid, sel, grant} !== {1'b1, 4'd4, 16'h0010}) begin
            n_fail++;
            $display("FAIL midrst_grant: got gv=%b sel=%h grant=%h, expected 1/4/0010",
                     grant_valid, sel, grant);
        end
        reset = 1'b1;
        tick();
        n_tests++;
        if ({grant_valid, sel, grant} !== {1'b0, 4'd0, 16'h0000}) begin
            n_fail++;
            $display("FAIL midrst_clear: got gv=%b sel=%h grant=%h, expected 0/0/0000",
                     grant_valid, sel, grant);
        end
        reset = 1'b0;
        tick();
        n_tests++;
        if ({grant_valid, sel, grant} !== {1'b1, 4'd4, 16'h0010}) begin
            n_fail++;
            $display("FAIL midrst_regrant: got gv=%b sel=%h grant=%h, expected 1/4/0010",
                     grant_valid, sel, grant);
        end
    endtask

    // Grant lasts one cycle because done is raised during it; gap cycle follows.
    task automatic test_full_rotation();
        logic [3:0]  es;
        logic [15:0] eg;
        do_reset();
        req = 16'hFFFF;
        for (int k = 0; k <= 16; k++) begin
            es = 4'(k % 16);
            eg = 16'h0001 << es;
            tick();
            n_tests++;
            if ({grant_valid, sel, grant} !== {1'b1, es, eg}) begin
                n_fail++;
                $display("FAIL rotation_grant[%0d]: got gv=%b sel=%h grant=%h, expected 1/%h/%h",
                         k, grant_valid, sel, grant, es, eg);
            end
            done = 1'b1;
            tick();
            done = 1'b0;
            n_tests++;
            if ({grant_valid, grant, timeout, sel} !== {1'b0, 16'h0000, 1'b0, es}) begin
                n_fail++;
                $display("FAIL rotation_gap[%0d]: got gv=%b grant=%h to=%b sel=%h, expected 0/0000/0/%h",
                         k, grant_valid, grant, timeout, sel, es);
            end
        end
    endtask

    task automatic test_skip_idle();
        logic [3:0]  es;
        logic [15:0] eg;
        do_reset();
        req = 16'hAAAA;
        for (int k = 0; k <= 8; k++) begin
            es = 4'((2 * k + 1) % 16);
            eg = 16'h0001 << es;
            tick();
            n_tests++;
            if ({grant_valid, sel, grant} !== {1'b1, es, eg}) begin
                n_fail++;
                $display("FAIL skip_grant[%0d]: got gv=%b sel=%h grant=%h, expected 1/%h/%h",
                         k, grant_valid, sel, grant, es, eg);
            end
            done = 1'b1;
            tick();
            done = 1'b0;
        end
    endtask

    // Also covers the single continuous requester: grant, gap, grant.
    task automatic test_timeout();
        do_reset();
        req = 16'h0100;
        for (int k = 0; k < 8; k++) begin
            tick();
            n_tests++;
            if ({grant_valid, sel, grant, timeout} !== {1'b1, 4'd8, 16'h0100, 1'b0}) begin
                n_fail++;
                $display("FAIL timeout_hold[%0d]: got gv=%b sel=%h grant=%h to=%b, expected 1/8/0100/0",
                         k, grant_valid, sel, grant, timeout);
            end
        end
        tick();
        n_tests++;
        if ({grant_valid, timeout, sel} !== {1'b0, 1'b1, 4'd8}) begin
            n_fail++;
            $display("FAIL timeout_release: got gv=%b to=%b sel=%h, expected 0/1/8",
                     grant_valid, timeout, sel);
        end
        tick();
        n_tests++;
        if ({grant_valid, timeout, sel} !== {1'b1, 1'b0, 4'd8}) begin
            n_fail++;
            $display("FAIL timeout_regrant: got gv=%b to=%b sel=%h, expected 1/0/8",
                     grant_valid, timeout, sel);
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        req = 16'h0100;
        for (int k = 0; k < 8; k++) begin
            tick();
        end
        // Owner is on its last allowed cycle; release via done at the same time.
        done = 1'b1;
        req  = 16'h0300;
        tick();
        done = 1'b0;
        n_tests++;
        if ({grant_valid, timeout} !== {1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL simul_release: got gv=%b to=%b, expected 0/0", grant_valid, timeout);
        end
        tick();
        n_tests++;
        if ({grant_valid, sel, grant} !== {1'b1, 4'd9, 16'h0200}) begin
            n_fail++;
            $display("FAIL simul_ptr: got gv=%b sel=%h grant=%h, expected 1/9/0200",
                     grant_valid, sel, grant);
        end
    endtask

    task automatic test_req_drop();
        do_reset();
        req = 16'h8000;
        tick();
        n_tests++;
        if ({grant_valid, sel, grant} !== {1'b1, 4'd15, 16'h8000}) begin
            n_fail++;
            $display("FAIL drop_grant15: got gv=%b sel=%h grant=%h, expected 1/f/8000",
                     grant_valid, sel, grant);
        end
        req = 16'h0001;
        tick();
        n_tests++;
        if ({grant_valid, timeout, sel, grant} !== {1'b0, 1'b0, 4'd15, 16'h0000}) begin
            n_fail++;
            $display("FAIL drop_release: got gv=%b to=%b sel=%h grant=%h, expected 0/0/f/0000",
                     grant_valid, timeout, sel, grant);
        end
        tick();
        n_tests++;
        if ({grant_valid, sel, grant} !== {1'b1, 4'd0, 16'h0001}) begin
            n_fail++;
            $display("FAIL drop_wrap: got gv=%b sel=%h grant=%h, expected 1/0/0001",
                     grant_valid, sel, grant);
        end
    endtask

    task automatic test_done_in_idle();
        do_reset();
        done = 1'b1;
        tick();
        tick();
        n_tests++;
        if ({grant_valid, timeout, grant} !== {1'b0, 1'b0, 16'h0000}) begin
            n_fail++;
            $display("FAIL idle_done: got gv=%b to=%b grant=%h, expected 0/0/0000",
                     grant_valid, timeout, grant);
        end
        done = 1'b0;
        req  = 16'h0040;
        tick();
        n_tests++;
        if ({grant_valid, sel} !== {1'b1, 4'd6}) begin
            n_fail++;
            $display("FAIL idle_done_next: got gv=%b sel=%h, expected 1/6", grant_valid, sel);
        end
    endtask

    task automatic test_max_hold_one();
        do_reset();
        req1 = 16'h0004;
        tick();
        n_tests++;
        if ({grant_valid1, sel1, timeout1} !== {1'b1, 4'd2, 1'b0}) begin
            n_fail++;
            $display("FAIL mh1_grant: got gv=%b sel=%h to=%b, expected 1/2/0",
                     grant_valid1, sel1, timeout1);
        end
        tick();
        n_tests++;
        if ({grant_valid1, timeout1} !== {1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL mh1_timeout: got gv=%b to=%b, expected 0/1", grant_valid1, timeout1);
        end
        tick();
        n_tests++;
        if ({grant_valid1, timeout1} !== {1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL mh1_regrant: got gv=%b to=%b, expected 1/0", grant_valid1, timeout1);
        end
        done1 = 1'b1;
        tick();
        done1 = 1'b0;
        n_tests++;
        if ({grant_valid1, timeout1} !== {1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL mh1_done: got gv=%b to=%b, expected 0/0", grant_valid1, timeout1);
        end
        tick();
        req1 = '0;
        tick();
        n_tests++;
        if ({grant_valid1, timeout1} !== {1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL mh1_drop: got gv=%b to=%b, expected 0/0", grant_valid1, timeout1);
        end
    endtask

    initial begin
        reset = 1'b1;
        req   = '0;
        done  = 1'b0;
        req1  = '0;
        done1 = 1'b0;
        test_reset();
        test_reset_mid_grant();
        test_full_rotation();
        test_skip_idle();
        test_timeout();
        test_simultaneous();
        test_req_drop();
        test_done_in_idle();
        test_max_hold_one();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
